// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: opcode encodings, FSM state type
// and the reference model used to check the external calculator's output.
package calc_pkg;

    localparam int CALC_W = 4;

    // Abs opcodes ignore bit 0; the listed values are the canonical encodings.
    localparam logic [2:0] OP_ADD_AB = 3'b000;
    localparam logic [2:0] OP_SUB_AB = 3'b001;
    localparam logic [2:0] OP_ABS_B  = 3'b010;
    localparam logic [2:0] OP_ADD_BA = 3'b100;
    localparam logic [2:0] OP_SUB_BA = 3'b101;
    localparam logic [2:0] OP_ABS_A  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RESP
    } seq_state_t;

    // Returns {ovf, r}; arithmetic is done one bit wider so overflow is a sign-bit disagreement.
    function automatic logic [CALC_W:0] calc_model(
        input logic [2:0]        op,
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] b
    );
        logic signed [CALC_W:0] ax;
        logic signed [CALC_W:0] bx;
        logic signed [CALC_W:0] res;
        ax  = {a[CALC_W-1], a};
        bx  = {b[CALC_W-1], b};
        res = '0;
        case (op)
            OP_ADD_AB:                      res = ax + bx;
            OP_SUB_AB:                      res = ax - bx;
            OP_ABS_B, OP_ABS_B | 3'b001:    res = bx[CALC_W] ? -bx : bx;
            OP_ADD_BA:                      res = bx + ax;
            OP_SUB_BA:                      res = bx - ax;
            OP_ABS_A, OP_ABS_A | 3'b001:    res = ax[CALC_W] ? -ax : ax;
            default:                        res = '0;
        endcase
        return {res[CALC_W] ^ res[CALC_W-1], res[CALC_W-1:0]};
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO holding {op, a, b} entries; full/empty are derived from the occupancy count.
module calc_cmd_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [3+2*W-1:0]       push_data,
    input  logic                   pop,
    output logic [3+2*W-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3 + 2 * W;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Feeds queued commands to the combinational calculator, captures and checks its
// result one cycle later, and offers each result on a valid/ready response port.
module calc_op_sequencer #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [W-1:0]           cmd_a,
    input  logic [W-1:0]           cmd_b,
    output logic [2:0]             calc_op,
    output logic [W-1:0]           calc_a,
    output logic [W-1:0]           calc_b,
    input  logic [W-1:0]           calc_r,
    input  logic                   calc_ovf,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [W-1:0]           rsp_r,
    output logic                   rsp_ovf,
    output logic [2:0]             rsp_op,
    output logic                   ovf_sticky,
    output logic                   chk_err,
    input  logic                   sticky_clear,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] cmd_count
);

    import calc_pkg::*;

    localparam int EW = 3 + 2 * W;

    seq_state_t     state_q, state_d;
    logic           rdy_en_q, rdy_en_d;
    logic [2:0]     calc_op_q, calc_op_d;
    logic [W-1:0]   calc_a_q, calc_a_d;
    logic [W-1:0]   calc_b_q, calc_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_r_q, rsp_r_d;
    logic           rsp_ovf_q, rsp_ovf_d;
    logic [2:0]     rsp_op_q, rsp_op_d;
    logic           ovf_sticky_q, ovf_sticky_d;
    logic           chk_err_q, chk_err_d;

    logic           fifo_full;
    logic           fifo_empty;
    logic [EW-1:0]  fifo_dout;
    logic           cmd_push;
    logic           fifo_pop;
    logic           rsp_hs;
    logic           capture;
    logic [W:0]     mdl;
    logic           mismatch;

    assign cmd_ready = rdy_en_q && !fifo_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rsp_hs    = (state_q == ST_RESP) && rsp_ready;
    assign capture   = (state_q == ST_DRIVE);
    assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || rsp_hs);
    assign mdl       = calc_model(calc_op_q, calc_a_q, calc_b_q);
    assign mismatch  = ({calc_ovf, calc_r} != mdl);

    calc_cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data ({cmd_op, cmd_a, cmd_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (cmd_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_DRIVE;
            ST_DRIVE: state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = fifo_empty ? ST_IDLE : ST_DRIVE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sticky updates put the set after the clear so a same-cycle set wins.
    always_comb begin
        rdy_en_d     = 1'b1;
        calc_op_d    = calc_op_q;
        calc_a_d     = calc_a_q;
        calc_b_d     = calc_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_r_d      = rsp_r_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_op_d     = rsp_op_q;
        ovf_sticky_d = ovf_sticky_q;
        chk_err_d    = chk_err_q;
        if (fifo_pop) begin
            calc_op_d = fifo_dout[EW-1 -: 3];
            calc_a_d  = fifo_dout[2*W-1 -: W];
            calc_b_d  = fifo_dout[W-1:0];
        end
        if (rsp_hs) begin
            rsp_valid_d = 1'b0;
        end
        if (sticky_clear) begin
            ovf_sticky_d = 1'b0;
            chk_err_d    = 1'b0;
        end
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_r_d     = calc_r;
            rsp_ovf_d   = calc_ovf;
            rsp_op_d    = calc_op_q;
            if (calc_ovf) ovf_sticky_d = 1'b1;
            if (mismatch) chk_err_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q     <= 1'b0;
            calc_op_q    <= '0;
            calc_a_q     <= '0;
            calc_b_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_r_q      <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_op_q     <= '0;
            ovf_sticky_q <= 1'b0;
            chk_err_q    <= 1'b0;
        end else begin
            rdy_en_q     <= rdy_en_d;
            calc_op_q    <= calc_op_d;
            calc_a_q     <= calc_a_d;
            calc_b_q     <= calc_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_r_q      <= rsp_r_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_op_q     <= rsp_op_d;
            ovf_sticky_q <= ovf_sticky_d;
            chk_err_q    <= chk_err_d;
        end
    end

    assign calc_op    = calc_op_q;
    assign calc_a     = calc_a_q;
    assign calc_b     = calc_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_r      = rsp_r_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_op     = rsp_op_q;
    assign ovf_sticky = ovf_sticky_q;
    assign chk_err    = chk_err_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench: a behavioural calculator stub, a response scoreboard,
// a vector table and hand-written sequences for stall, checker and reset corners.
module tb_calc_op_sequencer;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_r;
        logic         exp_ovf;
    } vec_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] r;
        logic         ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic [2:0]    calc_op;
    logic [W-1:0]  calc_a;
    logic [W-1:0]  calc_b;
    logic [W-1:0]  calc_r;
    logic          calc_ovf;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_r;
    logic          rsp_ovf;
    logic [2:0]    rsp_op;
    logic          ovf_sticky;
    logic          chk_err;
    logic          sticky_clear = 1'b0;
    logic          busy;
    logic [CW-1:0] cmd_count;

    logic          stub_bad = 1'b0;
    logic [W-1:0]  drv_exp_r = '0;
    logic          drv_exp_ovf = 1'b0;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rsp_seen = 0;
    exp_t sb_q[$];
    int   hs_q[$];

    logic         hold_valid = 1'b0;
    logic [W-1:0] hold_r = '0;
    logic         hold_ovf = 1'b0;
    logic [2:0]   hold_op = '0;

    calc_op_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .calc_op      (calc_op),
        .calc_a       (calc_a),
        .calc_b       (calc_b),
        .calc_r       (calc_r),
        .calc_ovf     (calc_ovf),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_r        (rsp_r),
        .rsp_ovf      (rsp_ovf),
        .rsp_op       (rsp_op),
        .ovf_sticky   (ovf_sticky),
        .chk_err      (chk_err),
        .sticky_clear (sticky_clear),
        .busy         (busy),
        .cmd_count    (cmd_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Exact integer reference: compute the true result, then wrap and range-check it.
    function automatic logic [W:0] ref_calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        int res;
        logic [W-1:0] r;
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0:       res = ia + ib;
            3'd1:       res = ia - ib;
            3'd2, 3'd3: res = (ib < 0) ? -ib : ib;
            3'd4:       res = ib + ia;
            3'd5:       res = ib - ia;
            default:    res = (ia < 0) ? -ia : ia;
        endcase
        r = res[W-1:0];
        return {(res < -(1 << (W-1))) || (res > (1 << (W-1)) - 1), r};
    endfunction

    always_comb begin
        {calc_ovf, calc_r} = ref_calc(calc_op, calc_a, calc_b);
        if (stub_bad) begin
            calc_r   = '0;
            calc_ovf = 1'b0;
        end
    end

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle, so handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        exp_t ne;
        exp_t e;
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                ne.op  = cmd_op;
                ne.r   = drv_exp_r;
                ne.ovf = drv_exp_ovf;
                sb_q.push_back(ne);
            end
            if (hold_valid) begin
                check_output("stall_valid", rsp_valid, 1);
                check_output("stall_r", rsp_r, hold_r);
                check_output("stall_ovf", rsp_ovf, hold_ovf);
                check_output("stall_op", rsp_op, hold_op);
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                hs_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rsp: got r=%0d op=%0d, expected no response", rsp_r, rsp_op);
                end else begin
                    e = sb_q.pop_front();
                    check_output("rsp_r", rsp_r, e.r);
                    check_output("rsp_ovf", rsp_ovf, e.ovf);
                    check_output("rsp_op", rsp_op, e.op);
                end
            end
            hold_valid = rsp_valid && !rsp_ready;
            hold_r     = rsp_r;
            hold_ovf   = rsp_ovf;
            hold_op    = rsp_op;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] er, input logic eo, output bit acc);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        drv_exp_r   = er;
        drv_exp_ovf = eo;
        @(negedge clk);
        acc = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] er, input logic eo);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) apply_stimulus(op, a, b, er, eo, acc);
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL push_timeout: got cmd_ready=0, expected acceptance within 50 cycles");
        end
    endtask

    task automatic push_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] e;
        e = ref_calc(op, a, b);
        push_cmd(op, a, b, e[W-1:0], e[W]);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) done = 1'b1;
        end
        check_output("drain_done", done, 1);
        tick();
    endtask

    task automatic pulse_clear();
        sticky_clear = 1'b1;
        tick();
        sticky_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       tbl[10];
        vec_t       stall_tbl[6];
        logic [W:0] e;
        bit         acc;
        int         n_acc;
        int         seen0;

        tbl[0] = '{3'b101, 4'(3),  4'(-2), 4'(-5), 1'b0};
        tbl[1] = '{3'b110, 4'(-8), 4'(0),  4'(-8), 1'b1};
        tbl[2] = '{3'b010, 4'(0),  4'(-3), 4'(3),  1'b0};
        tbl[3] = '{3'b001, 4'(-8), 4'(1),  4'(7),  1'b1};
        tbl[4] = '{3'b100, 4'(2),  4'(5),  4'(7),  1'b0};
        tbl[5] = '{3'b011, 4'(0),  4'(5),  4'(5),  1'b0};
        tbl[6] = '{3'b111, 4'(7),  4'(0),  4'(7),  1'b0};
        tbl[7] = '{3'b000, 4'(-8), 4'(-8), 4'(0),  1'b1};
        tbl[8] = '{3'b101, 4'(-8), 4'(7),  4'(-1), 1'b1};
        tbl[9] = '{3'b001, 4'(-1), 4'(-1), 4'(0),  1'b0};

        stall_tbl[0] = '{3'b000, 4'(1),  4'(2),  4'(0), 1'b0};
        stall_tbl[1] = '{3'b001, 4'(5),  4'(2),  4'(0), 1'b0};
        stall_tbl[2] = '{3'b100, 4'(-3), 4'(-4), 4'(0), 1'b0};
        stall_tbl[3] = '{3'b010, 4'(0),  4'(-7), 4'(0), 1'b0};
        stall_tbl[4] = '{3'b101, 4'(1),  4'(6),  4'(0), 1'b0};
        stall_tbl[5] = '{3'b000, 4'(2),  4'(2),  4'(0), 1'b0};

        repeat (3) tick();
        check_output("reset_cmd_ready", cmd_ready, 0);
        check_output("reset_rsp_valid", rsp_valid, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_cmd_count", cmd_count, 0);
        check_output("reset_calc_op", calc_op, 0);
        check_output("reset_calc_a", calc_a, 0);
        check_output("reset_calc_b", calc_b, 0);
        check_output("reset_rsp_r", rsp_r, 0);
        check_output("reset_ovf_sticky", ovf_sticky, 0);
        check_output("reset_chk_err", chk_err, 0);
        rst_n = 1'b1;
        tick();
        check_output("post_reset_cmd_ready", cmd_ready, 1);

        rsp_ready = 1'b1;
        push_cmd(3'b000, 4'(3), 4'(2), 4'(5), 1'b0);
        check_output("latency_n0", rsp_valid, 0);
        tick();
        check_output("latency_n1", rsp_valid, 0);
        tick();
        check_output("latency_n2", rsp_valid, 1);
        wait_idle();
        check_output("add_chk_err", chk_err, 0);
        check_output("add_ovf_sticky", ovf_sticky, 0);

        push_cmd(3'b000, 4'(7), 4'(1), 4'(-8), 1'b1);
        wait_idle();
        check_output("ovf_sticky_set", ovf_sticky, 1);
        pulse_clear();
        check_output("ovf_sticky_cleared", ovf_sticky, 0);

        for (int i = 0; i < 10; i++) push_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_r, tbl[i].exp_ovf);
        wait_idle();
        check_output("table_chk_err", chk_err, 0);
        check_output("table_ovf_sticky", ovf_sticky, 1);

        pulse_clear();
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            e = ref_calc(stall_tbl[i].op, stall_tbl[i].a, stall_tbl[i].b);
            apply_stimulus(stall_tbl[i].op, stall_tbl[i].a, stall_tbl[i].b, e[W-1:0], e[W], acc);
            n_acc += int'(acc);
        end
        check_output("stall_accepted", n_acc, 5);
        check_output("stall_cmd_ready", cmd_ready, 0);
        check_output("stall_cmd_count", cmd_count, 4);
        repeat (3) tick();
        hs_q.delete();
        rsp_ready = 1'b1;
        wait_idle();
        check_output("drain_count", hs_q.size(), 5);
        for (int i = 1; i < hs_q.size(); i++) check_output("drain_spacing", hs_q[i] - hs_q[i-1], 2);

        pulse_clear();
        check_output("chk_err_clear0", chk_err, 0);
        stub_bad = 1'b1;
        push_cmd(3'b000, 4'(1), 4'(1), 4'(0), 1'b0);
        wait_idle();
        check_output("chk_err_set", chk_err, 1);
        repeat (3) tick();
        check_output("chk_err_sticky", chk_err, 1);
        push_cmd(3'b000, 4'(1), 4'(1), 4'(0), 1'b0);
        tick();
        sticky_clear = 1'b1;
        tick();
        sticky_clear = 1'b0;
        check_output("chk_err_set_wins", chk_err, 1);
        wait_idle();
        stub_bad = 1'b0;
        pulse_clear();
        check_output("chk_err_clear1", chk_err, 0);

        rsp_ready = 1'b0;
        push_ref(3'b000, 4'(1), 4'(1));
        push_ref(3'b001, 4'(2), 4'(1));
        push_ref(3'b100, 4'(3), 4'(3));
        push_ref(3'b101, 4'(1), 4'(4));
        check_output("pre_rst_count3", cmd_count, 3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("pre_rst_count2", cmd_count, 2);
        check_output("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_cmd_count", cmd_count, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_cmd_ready", cmd_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen0 = rsp_seen;
        repeat (20) tick();
        check_output("no_stale_rsp", rsp_seen - seen0, 0);
        check_output("post_rst_busy", busy, 0);
        check_output("post_rst_cmd_ready", cmd_ready, 1);

        push_cmd(3'b100, 4'(-3), 4'(5), 4'(2), 1'b0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Sequential front-end and result collector for the combinational 4-bit signed calculator. Accepts opcode/operand commands over a valid/ready interface and buffers them in a small FIFO. Drives the calculator's OP/A/B inputs, samples its R/ovf outputs, checks each result against an internal model, and returns results over a second valid/ready interface. It owns the driving side of the calculator interface and also sits on its result side.

Parameters:
W, 4, operand/result width (signed two's complement), must match calculator width
DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_op  in  3  opcode
cmd_a  in  W  operand A
cmd_b  in  W  operand B
calc_op  out  3  to calculator OP
calc_a  out  W  to calculator A
calc_b  out  W  to calculator B
calc_r  in  W  calculator result
calc_ovf  in  1  calculator overflow
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_r  out  W  captured result
rsp_ovf  out  1  captured overflow
rsp_op  out  3  opcode of this result
ovf_sticky  out  1  set by any captured overflow
chk_err  out  1  sticky: calculator output disagreed with model
sticky_clear  in  1  clears ovf_sticky and chk_err
busy  out  1  FIFO non-empty or FSM not IDLE
cmd_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Opcode map: 000 A+B; 001 A-B; 01x abs(B); 100 B+A; 101 B-A; 11x abs(A).
- Model arithmetic is done at W+1 bits, and R is the low W bits. ovf=1 when the exact result is outside [-2^(W-1), 2^(W-1)-1]. abs(-2^(W-1)) gives R=-2^(W-1) with ovf=1.
- Reset (async, rst_n=0): FIFO emptied; state IDLE; all outputs 0 (calc_*, rsp_*, stickies, busy, cmd_count); cmd_ready=0 while in reset, then 1 from the first cycle after release. In-flight and queued commands are discarded.
- Push: on cmd_valid&&cmd_ready. cmd_ready = !full, with no bypass when full even if a pop happens in the same cycle. Push and pop in the same cycle leave count unchanged.
- FSM states IDLE, DRIVE, RESP.
- IDLE: if FIFO non-empty, pop the head into calc_op/a/b registers and go to DRIVE.
- DRIVE: lasts exactly one cycle (calculator settling). At the closing edge, capture calc_r/calc_ovf into rsp_r/rsp_ovf, latch rsp_op, compare against the model, set rsp_valid, and go to RESP.
- RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On the handshake, clear rsp_valid. If the FIFO is non-empty, pop into calc_* and go to DRIVE; otherwise go to IDLE.
- Latency: command pushed into an empty FIFO at edge N with the FSM idle produces rsp_valid high after edge N+2. Sustained throughput is one result per 2 cycles.
- calc_op/a/b change only on a pop; they hold their last values otherwise.
- ovf_sticky set on capture when calc_ovf=1. chk_err set on capture when {calc_r,calc_ovf} differs from the model.
- sticky_clear clears both stickies. If sticky_clear and a set happen in the same cycle, set wins.
- FIFO wrap: read and write pointers are modulo DEPTH; full/empty come from cmd_count.

Decomposition:
- Package calc_pkg holds:
  - opcode localparams (OP_ADD_AB=3'b000, OP_SUB_AB=3'b001, OP_ABS_B=3'b01?, OP_ADD_BA=3'b100, OP_SUB_BA=3'b101, OP_ABS_A=3'b11?);
  - FSM state typedef;
  - model function calc_model(op,a,b) returning {ovf,r}.
- Sub-module calc_cmd_fifo (parameterised W, DEPTH; 3+2W-bit entries; push/pop/full/empty/count). The FSM, capture and checker stay in the top.

Test Plan:
- Push op=000 A=3 B=2, rsp_ready=1 -> rsp_valid after edge N+2, rsp_r=5, rsp_ovf=0, chk_err=0.
- Push op=000 A=7 B=1 -> rsp_r=-8, rsp_ovf=1, ovf_sticky=1. Then pulse sticky_clear -> ovf_sticky=0.
- Push op=101 A=3 B=-2 -> rsp_r=-5, ovf=0. Push op=110 A=-8 -> rsp_r=-8, ovf=1. Push op=010 B=-3 -> rsp_r=3.
- Hold rsp_ready=0 and offer 6 commands -> 5 accepted (1 in RESP, 4 in FIFO), cmd_ready=0, cmd_count=4. Release rsp_ready -> results arrive in order, one per 2 cycles, rsp_* stable while stalled.
- Stub calculator returns R=0 for op=000 A=1 B=1 -> chk_err=1 and stays set. sticky_clear in the same cycle as a new mismatch capture -> chk_err remains 1.
- Assert rst_n=0 while in DRIVE with 2 queued -> immediately rsp_valid=0, cmd_count=0, busy=0. After release, no stale responses appear.
